// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtracter.
// The carry chain is cut into STAGES slices of SLICE bits with a register
// between slices. Each op carries its own add/sub and wrap/saturate select.
// A single global enable (out_ready | ~out_valid) advances or freezes the
// whole pipe, giving valid/ready streaming at one op per cycle.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             op_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SLICE = WIDTH / STAGES;
  // Inter-stage registers exist only between slices; keep at least one entry
  // so the array is legal when STAGES == 1.
  localparam int NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

  // Everything an op needs while it walks down the carry chain. Operands are
  // kept raw (b is inverted per slice); sum collects finished slices in place.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             cy;
    logic [WIDTH-1:0] sum;
  } stage_t;

  logic           en;
  stage_t         pipe_q  [NPIPE];
  stage_t         stg_in  [STAGES];
  stage_t         stg_out [STAGES];
  logic [SLICE:0] slice_sum [STAGES];

  stage_t           fin;
  logic             sign_a;
  logic             sign_b;
  logic             sign_r;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;
  logic [WIDTH-1:0] res_d;

  // One enable for every stage: move when the output slot is free or draining.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Slice adders: stage k adds its SLICE of a and (possibly inverted) b plus
  // the carry registered by stage k-1; stage 0 takes op_sub as carry-in.
  always_comb begin
    stg_in[0]     = '0;
    stg_in[0].vld = in_valid;
    stg_in[0].a   = a;
    stg_in[0].b   = b;
    stg_in[0].sub = op_sub;
    stg_in[0].sat = op_sat;
    stg_in[0].cy  = op_sub;
    for (int k = 1; k < STAGES; k++) begin
      stg_in[k] = pipe_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, stg_in[k].a[k*SLICE +: SLICE]}
                   + {1'b0, stg_in[k].b[k*SLICE +: SLICE] ^ {SLICE{stg_in[k].sub}}}
                   + {{SLICE{1'b0}}, stg_in[k].cy};
      // NOTE: every field of stg_out is assigned from stg_in before the slice
      // is patched in, so no path through this block can infer a latch.
      stg_out[k]                          = stg_in[k];
      stg_out[k].sum[k*SLICE +: SLICE]    = slice_sum[k][SLICE-1:0];
      stg_out[k].cy                       = slice_sum[k][SLICE];
    end
  end

  // Last stage: derive flags from the raw sum, then apply saturation.
  always_comb begin
    fin    = stg_out[STAGES-1];
    sign_a = fin.a[WIDTH-1];
    sign_b = fin.b[WIDTH-1] ^ fin.sub;
    sign_r = fin.sum[WIDTH-1];
    ovf_d  = (sign_a == sign_b) && (sign_r != sign_a);
    res_d  = fin.sum;
    if (fin.sat && ovf_d) begin
      res_d = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_d = (res_d == '0);
    neg_d  = res_d[WIDTH-1];
  end

  // Pipeline and output registers: all advance together on en, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand/sum registers are cleared too, not just the valids,
      // so the outputs read as zero while in reset and after a mid-op reset.
      for (int k = 0; k < NPIPE; k++) begin
        pipe_q[k] <= '0;
      end
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking updates let each stage read the previous stage's
      // old value within the same edge, which is what makes this a pipeline.
      for (int k = 0; k < STAGES - 1; k++) begin
        pipe_q[k] <= stg_out[k];
      end
      out_valid <= fin.vld;
      result    <= res_d;
      cout      <= fin.cy;
      ovf       <= ovf_d;
      zero      <= zero_d;
      neg       <= neg_d;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: random and directed ops against an integer-arithmetic model,
// with an in-order scoreboard, latency counting and stall/reset checks.
module tb_addsub_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             op_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
    int               en_at;
  } exp_t;

  exp_t             sb [$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               en_cnt   = 0;
  logic             rand_ready = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_result;
  logic [3:0]       prev_flags;
  logic             en_now;
  exp_t             e;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .op_sat    (op_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed result in plain integers, then wrap or clamp.
  function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic ts, input logic tt);
    exp_t r;
    int   sa    = $signed(ta);
    int   sbv   = $signed(tb);
    int   ua    = int'(ta);
    int   ub    = int'(tb);
    int   exact = ts ? sa - sbv : sa + sbv;
    r.ovf  = (exact > 127) || (exact < -128);
    r.cout = ts ? (ua >= ub) : (ua + ub > 255);
    if (tt && exact > 127)       r.res = 8'h7F;
    else if (tt && exact < -128) r.res = 8'h80;
    else                         r.res = exact[7:0];
    r.zero  = (r.res == 8'h00);
    r.neg   = r.res[7];
    r.en_at = 0;
    return r;
  endfunction

  // Monitor on the falling edge: the values seen here decide the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      en_now = out_ready | ~out_valid;
      check("in_ready", in_ready, en_now);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", result, prev_result);
        check("hold_flags", {cout, ovf, zero, neg}, prev_flags);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_without_op", out_valid, 0);
        end else if (out_ready) begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("cout", cout, e.cout);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
          check("neg", neg, e.neg);
          check("latency", en_cnt - e.en_at, STAGES);
        end
      end
      if (in_valid && in_ready) begin
        e       = model(a, b, op_sub, op_sat);
        e.en_at = en_cnt;
        sb.push_back(e);
      end
      if (en_now) en_cnt++;
      prev_stall  = out_valid & ~out_ready;
      prev_result = result;
      prev_flags  = {cout, ovf, zero, neg};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic ts, input logic tt);
    int guard = 0;
    a        = ta;
    b        = tb;
    op_sub   = ts;
    op_sat   = tt;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 500) begin
        check("send_timeout", guard, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    op_sat    = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {cout, ovf, zero, neg}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Directed corner cases: overflow, saturation both ways, borrow, zero.
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b1);
    send(8'h80, 8'hFF, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b1, 1'b0);
    send(8'h10, 8'h10, 1'b1, 1'b0);
    send(8'h80, 8'h01, 1'b1, 1'b1);
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    drain();

    // Random back-to-back ops under random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset with two ops in flight: output must drop at once and stay empty.
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b1, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_result", result, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(8'h12, 8'h34, 1'b0, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
